// File: rtl/native_bus_initiator.sv
// Native-bus (PicoRV32-style valid/ready) initiator: turns single commands into one
// bus transaction each and reports status, read data and latency as a response pulse.
module native_bus_initiator #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned LAT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic             cmd_instr,
    input  logic [31:0]      cmd_addr,
    input  logic [31:0]      cmd_wdata,
    input  logic [3:0]       cmd_wstrb,
    output logic             rsp_valid,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_error,
    output logic             mem_valid,
    output logic             mem_instr,
    input  logic             mem_ready,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic [31:0]      mem_rdata,
    output logic             busy,
    output logic [31:0]      txn_count,
    output logic [7:0]       err_count,
    output logic [LAT_W-1:0] last_latency
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [LAT_W-1:0] LAT_MAX     = '1;
    localparam logic [LAT_W-1:0] LAT_ONE     = LAT_W'(1);
    localparam logic [LAT_W-1:0] LAT_TIMEOUT = LAT_W'(TIMEOUT);

    state_t             state_q,        state_d;
    logic               cmd_ready_q,    cmd_ready_d;
    logic               busy_q,         busy_d;
    logic               mem_valid_q,    mem_valid_d;
    logic               mem_instr_q,    mem_instr_d;
    logic [31:0]        mem_addr_q,     mem_addr_d;
    logic [31:0]        mem_wdata_q,    mem_wdata_d;
    logic [3:0]         mem_wstrb_q,    mem_wstrb_d;
    logic               write_q,        write_d;
    logic [LAT_W-1:0]   lat_q,          lat_d;
    logic               rsp_valid_q,    rsp_valid_d;
    logic [31:0]        rsp_rdata_q,    rsp_rdata_d;
    logic               rsp_error_q,    rsp_error_d;
    logic [31:0]        txn_count_q,    txn_count_d;
    logic [7:0]         err_count_q,    err_count_d;
    logic [LAT_W-1:0]   last_latency_q, last_latency_d;

    logic               cmd_err_c;
    logic [7:0]         err_count_inc_c;

    // Commands rejected without touching the bus.
    assign cmd_err_c       = (cmd_addr[1:0] != 2'b00) || (cmd_write && (cmd_wstrb == 4'h0));
    assign err_count_inc_c = (err_count_q != 8'hFF) ? (err_count_q + 8'd1) : err_count_q;

    always_comb begin
        state_d        = state_q;
        mem_valid_d    = mem_valid_q;
        mem_instr_d    = mem_instr_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        mem_wstrb_d    = mem_wstrb_q;
        write_d        = write_q;
        lat_d          = lat_q;
        rsp_valid_d    = 1'b0;
        rsp_rdata_d    = rsp_rdata_q;
        rsp_error_d    = rsp_error_q;
        txn_count_d    = txn_count_q;
        err_count_d    = err_count_q;
        last_latency_d = last_latency_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_err_c) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                        rsp_rdata_d = 32'h0;
                        err_count_d = err_count_inc_c;
                    end else begin
                        state_d     = REQ;
                        mem_valid_d = 1'b1;
                        write_d     = cmd_write;
                        mem_addr_d  = cmd_addr;
                        mem_instr_d = cmd_write ? 1'b0 : cmd_instr;
                        mem_wdata_d = cmd_write ? cmd_wdata : 32'h0;
                        mem_wstrb_d = cmd_write ? cmd_wstrb : 4'h0;
                        lat_d       = LAT_ONE;
                    end
                end
            end

            REQ: begin
                // A ready arriving on the timeout cycle still counts as success.
                if (mem_ready) begin
                    state_d        = RESP;
                    mem_valid_d    = 1'b0;
                    rsp_valid_d    = 1'b1;
                    rsp_error_d    = 1'b0;
                    rsp_rdata_d    = write_q ? 32'h0 : mem_rdata;
                    last_latency_d = lat_q;
                    txn_count_d    = txn_count_q + 32'd1;
                end else if (lat_q == LAT_TIMEOUT) begin
                    state_d        = RESP;
                    mem_valid_d    = 1'b0;
                    rsp_valid_d    = 1'b1;
                    rsp_error_d    = 1'b1;
                    rsp_rdata_d    = 32'h0;
                    last_latency_d = LAT_TIMEOUT;
                    err_count_d    = err_count_inc_c;
                end else if (lat_q != LAT_MAX) begin
                    lat_d = lat_q + LAT_ONE;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d     = IDLE;
                mem_valid_d = 1'b0;
            end
        endcase

        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cmd_ready_q    <= 1'b1;
            busy_q         <= 1'b0;
            mem_valid_q    <= 1'b0;
            mem_instr_q    <= 1'b0;
            mem_addr_q     <= 32'h0;
            mem_wdata_q    <= 32'h0;
            mem_wstrb_q    <= 4'h0;
            write_q        <= 1'b0;
            lat_q          <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_rdata_q    <= 32'h0;
            rsp_error_q    <= 1'b0;
            txn_count_q    <= 32'h0;
            err_count_q    <= 8'h0;
            last_latency_q <= '0;
        end else begin
            state_q        <= state_d;
            cmd_ready_q    <= cmd_ready_d;
            busy_q         <= busy_d;
            mem_valid_q    <= mem_valid_d;
            mem_instr_q    <= mem_instr_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_wstrb_q    <= mem_wstrb_d;
            write_q        <= write_d;
            lat_q          <= lat_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_rdata_q    <= rsp_rdata_d;
            rsp_error_q    <= rsp_error_d;
            txn_count_q    <= txn_count_d;
            err_count_q    <= err_count_d;
            last_latency_q <= last_latency_d;
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign busy         = busy_q;
    assign mem_valid    = mem_valid_q;
    assign mem_instr    = mem_instr_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_wstrb    = mem_wstrb_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_error    = rsp_error_q;
    assign txn_count    = txn_count_q;
    assign err_count    = err_count_q;
    assign last_latency = last_latency_q;

endmodule

// File: tb/tb_native_bus_initiator.sv
// Bench for native_bus_initiator: directed vector table, back-to-back and reset
// sequences, then random commands checked against a transaction-level model.
module tb_native_bus_initiator;

    localparam int unsigned TO = 8;
    localparam int unsigned LW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready, cmd_write, cmd_instr;
    logic [31:0]   cmd_addr, cmd_wdata;
    logic [3:0]    cmd_wstrb;
    logic          rsp_valid, rsp_error;
    logic [31:0]   rsp_rdata;
    logic          mem_valid, mem_instr, mem_ready;
    logic [31:0]   mem_addr, mem_wdata, mem_rdata;
    logic [3:0]    mem_wstrb;
    logic          busy;
    logic [31:0]   txn_count;
    logic [7:0]    err_count;
    logic [LW-1:0] last_latency;

    native_bus_initiator #(.TIMEOUT(TO), .LAT_W(LW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_instr(cmd_instr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .cmd_wstrb(cmd_wstrb), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .mem_valid(mem_valid), .mem_instr(mem_instr),
        .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .busy(busy),
        .txn_count(txn_count), .err_count(err_count), .last_latency(last_latency)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          waits;
        logic [31:0] rdata;
    } cmd_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          nvalid;
        logic [LW-1:0] lat;
    } exp_t;

    typedef struct {
        cmd_t c;
        exp_t e;
    } vec_t;

    typedef struct {
        int          nvalid;
        int          rsp_i;
        logic        got_rsp;
        logic        mv_at_rsp;
        logic        pulse_ok;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        instr;
        logic        stable;
        logic [31:0] rdata;
        logic        err;
    } obs_t;

    int            checks = 0;
    int            failures = 0;
    int            exp_txn = 0;
    int            exp_err = 0;
    logic [LW-1:0] exp_lat = '0;
    bit            noise_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic cmd_t mk_cmd(input logic wr, input logic instr, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [3:0] wstrb,
                                    input int waits, input logic [31:0] rdata);
        cmd_t c;
        c.wr = wr; c.instr = instr; c.addr = addr; c.wdata = wdata;
        c.wstrb = wstrb; c.waits = waits; c.rdata = rdata;
        return c;
    endfunction

    function automatic exp_t mk_exp(input logic err, input logic [31:0] rdata,
                                    input int nvalid, input int lat);
        exp_t e;
        e.err = err; e.rdata = rdata; e.nvalid = nvalid; e.lat = LW'(lat);
        return e;
    endfunction

    // Transaction-level expectation from the command rules and responder wait count.
    function automatic exp_t model(input cmd_t c, input logic [LW-1:0] prev_lat);
        exp_t e;
        logic [1:0] lo;
        lo = c.addr[1:0];
        if (lo != 2'b00 || (c.wr && c.wstrb == 4'h0)) begin
            e.err = 1'b1; e.rdata = 32'h0; e.nvalid = 0; e.lat = prev_lat;
        end else if (c.waits + 1 > int'(TO)) begin
            e.err = 1'b1; e.rdata = 32'h0; e.nvalid = int'(TO); e.lat = LW'(TO);
        end else begin
            e.err = 1'b0;
            e.rdata = c.wr ? 32'h0 : c.rdata;
            e.nvalid = c.waits + 1;
            e.lat = LW'(c.waits + 1);
        end
        return e;
    endfunction

    // Issue one command, act as the responder, and record what the bus and response did.
    task automatic run_cmd(input cmd_t c, output obs_t o);
        int nv;
        bit done;
        o.nvalid = 0; o.rsp_i = 0; o.got_rsp = 1'b0; o.mv_at_rsp = 1'b0; o.pulse_ok = 1'b0;
        o.addr = 32'h0; o.wdata = 32'h0; o.wstrb = 4'h0; o.instr = 1'b0; o.stable = 1'b1;
        o.rdata = 32'h0; o.err = 1'b0;
        nv = 0;
        done = 1'b0;
        for (int w = 0; w < 20 && !cmd_ready; w++) begin
            @(posedge clk); #1;
        end
        chk("idle_before_cmd", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_write = c.wr; cmd_instr = c.instr; cmd_addr = c.addr;
        cmd_wdata = c.wdata; cmd_wstrb = c.wstrb;
        mem_ready = noise_en ? 1'($urandom) : 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
        cmd_write = 1'($urandom); cmd_instr = 1'($urandom);
        for (int i = 1; i <= int'(TO) + 12 && !done; i++) begin
            if (rsp_valid) begin
                done = 1'b1;
                o.got_rsp = 1'b1; o.rsp_i = i; o.mv_at_rsp = mem_valid;
                o.rdata = rsp_rdata; o.err = rsp_error;
                mem_ready = noise_en ? 1'($urandom) : 1'b0;
                mem_rdata = $urandom;
            end else if (mem_valid) begin
                nv++;
                if (nv == 1) begin
                    o.addr = mem_addr; o.wdata = mem_wdata; o.wstrb = mem_wstrb; o.instr = mem_instr;
                end else if (mem_addr !== o.addr || mem_wdata !== o.wdata ||
                             mem_wstrb !== o.wstrb || mem_instr !== o.instr) begin
                    o.stable = 1'b0;
                end
                mem_ready = (nv == c.waits + 1);
                mem_rdata = mem_ready ? c.rdata : $urandom;
            end else begin
                mem_ready = 1'b0;
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        o.nvalid = nv;
        o.pulse_ok = !rsp_valid && cmd_ready && !mem_valid;
    endtask

    task automatic verify(input string tag, input cmd_t c, input exp_t e, input obs_t o);
        chk({tag, ".got_rsp"}, 32'(o.got_rsp), 32'd1);
        chk({tag, ".nvalid"}, 32'(o.nvalid), 32'(e.nvalid));
        chk({tag, ".rsp_cycle"}, 32'(o.rsp_i), 32'(e.nvalid == 0 ? 1 : e.nvalid + 1));
        chk({tag, ".mv_at_rsp"}, 32'(o.mv_at_rsp), 32'd0);
        chk({tag, ".pulse_once"}, 32'(o.pulse_ok), 32'd1);
        chk({tag, ".rsp_error"}, 32'(o.err), 32'(e.err));
        chk({tag, ".rsp_rdata"}, o.rdata, e.rdata);
        if (e.nvalid > 0) begin
            chk({tag, ".mem_addr"}, o.addr, c.addr);
            chk({tag, ".mem_wstrb"}, 32'(o.wstrb), 32'(c.wr ? c.wstrb : 4'h0));
            chk({tag, ".mem_wdata"}, o.wdata, c.wr ? c.wdata : 32'h0);
            chk({tag, ".mem_instr"}, 32'(o.instr), 32'(c.wr ? 1'b0 : c.instr));
            chk({tag, ".stable"}, 32'(o.stable), 32'd1);
        end
        if (e.err) exp_err = (exp_err < 255) ? exp_err + 1 : 255;
        else       exp_txn++;
        exp_lat = e.lat;
        chk({tag, ".last_latency"}, 32'(last_latency), 32'(exp_lat));
        chk({tag, ".txn_count"}, txn_count, 32'(exp_txn));
        chk({tag, ".err_count"}, 32'(err_count), 32'(exp_err));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        obs_t o;
        cmd_t c;
        exp_t e;
        int   acc[$];
        int   nacc, nrsp, nv, viol;

        vecs[0] = '{c: mk_cmd(1'b0, 1'b0, 32'h100, 32'h0,        4'h0, 0,    32'hDEADBEEF),
                    e: mk_exp(1'b0, 32'hDEADBEEF, 1, 1)};
        vecs[1] = '{c: mk_cmd(1'b1, 1'b1, 32'h204, 32'h12345678, 4'h3, 3,    32'hFFFFFFFF),
                    e: mk_exp(1'b0, 32'h0, 4, 4)};
        vecs[2] = '{c: mk_cmd(1'b0, 1'b0, 32'h102, 32'h0,        4'h0, 0,    32'h11111111),
                    e: mk_exp(1'b1, 32'h0, 0, 4)};
        vecs[3] = '{c: mk_cmd(1'b1, 1'b0, 32'h208, 32'hAAAA5555, 4'h0, 0,    32'h22222222),
                    e: mk_exp(1'b1, 32'h0, 0, 4)};
        vecs[4] = '{c: mk_cmd(1'b0, 1'b1, 32'h300, 32'h0,        4'h0, 1000, 32'h33333333),
                    e: mk_exp(1'b1, 32'h0, 8, 8)};
        vecs[5] = '{c: mk_cmd(1'b0, 1'b1, 32'h304, 32'h0,        4'h0, 7,    32'hCAFEF00D),
                    e: mk_exp(1'b0, 32'hCAFEF00D, 8, 8)};
        vecs[6] = '{c: mk_cmd(1'b1, 1'b0, 32'h40C, 32'h0F0F0F0F, 4'hF, 8,    32'h44444444),
                    e: mk_exp(1'b1, 32'h0, 8, 8)};
        vecs[7] = '{c: mk_cmd(1'b0, 1'b0, 32'h010, 32'h0,        4'h0, 2,    32'h0BADF00D),
                    e: mk_exp(1'b0, 32'h0BADF00D, 3, 3)};

        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_instr = 1'b0;
        cmd_addr = 32'h0; cmd_wdata = 32'h0; cmd_wstrb = 4'h0;
        mem_ready = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset.mem_valid", 32'(mem_valid), 32'd0);
        chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.txn_count", txn_count, 32'd0);
        chk("reset.err_count", 32'(err_count), 32'd0);
        chk("reset.last_latency", 32'(last_latency), 32'd0);
        chk("reset.rsp_rdata", rsp_rdata, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i].c, o);
            verify($sformatf("vec%0d", i), vecs[i].c, vecs[i].e, o);
        end

        // Back-to-back reads with cmd_valid held high, one responder wait each.
        nacc = 0; nrsp = 0; nv = 0; viol = 0;
        cmd_write = 1'b0; cmd_instr = 1'b0; cmd_addr = 32'h500; cmd_wstrb = 4'h0;
        cmd_valid = 1'b1;
        for (int cyc = 0; cyc < 60 && nrsp < 5; cyc++) begin
            if (nacc == 5) cmd_valid = 1'b0;
            if (busy == cmd_ready) viol++;
            if (cmd_valid && cmd_ready) begin
                acc.push_back(cyc);
                nacc++;
                nv = 0;
            end
            if (rsp_valid) begin
                chk($sformatf("b2b%0d.rsp_rdata", nrsp), rsp_rdata, 32'h5000_0000 + 32'(nrsp));
                chk($sformatf("b2b%0d.rsp_error", nrsp), 32'(rsp_error), 32'd0);
                nrsp++;
            end
            if (mem_valid) begin
                nv++;
                mem_ready = (nv == 2);
                mem_rdata = 32'h5000_0000 + 32'(nrsp);
            end else begin
                mem_ready = 1'b0;
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        mem_ready = 1'b0;
        chk("b2b.accepts", 32'(nacc), 32'd5);
        chk("b2b.responses", 32'(nrsp), 32'd5);
        for (int i = 1; i < acc.size(); i++)
            chk($sformatf("b2b.spacing%0d", i), 32'(acc[i] - acc[i-1]), 32'd4);
        chk("b2b.ready_vs_busy", 32'(viol), 32'd0);
        exp_txn += 5;
        exp_lat = LW'(2);
        chk("b2b.txn_count", txn_count, 32'(exp_txn));
        chk("b2b.last_latency", 32'(last_latency), 32'(exp_lat));

        noise_en = 1'b1;
        for (int n = 0; n < 40; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            c.wr    = 1'($urandom);
            c.instr = 1'($urandom);
            c.addr  = {$urandom} & 32'hFFFF_FFFC;
            if ($urandom_range(0, 4) == 0) c.addr[1:0] = 2'($urandom_range(1, 3));
            c.wdata = $urandom;
            c.wstrb = 4'($urandom_range(0, 15));
            c.rdata = $urandom;
            if (r < 7)       c.waits = r % 4;
            else if (r == 7) c.waits = int'(TO) - 1;
            else             c.waits = int'($urandom_range(TO, TO + 4));
            e = model(c, exp_lat);
            run_cmd(c, o);
            verify($sformatf("rnd%0d", n), c, e, o);
        end
        noise_en = 1'b0;

        // Reset landing on the second REQ cycle abandons the transaction.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_instr = 1'b0; cmd_addr = 32'h600; cmd_wstrb = 4'h0;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("rst.req1_mem_valid", 32'(mem_valid), 32'd1);
        @(posedge clk); #1;
        chk("rst.req2_mem_valid", 32'(mem_valid), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst.mem_valid", 32'(mem_valid), 32'd0);
        chk("rst.cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.txn_count", txn_count, 32'd0);
        chk("rst.err_count", 32'(err_count), 32'd0);
        chk("rst.last_latency", 32'(last_latency), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst.after_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.after_mem_valid", 32'(mem_valid), 32'd0);
        exp_txn = 0; exp_err = 0; exp_lat = '0;

        run_cmd(vecs[0].c, o);
        verify("post_rst", vecs[0].c, vecs[0].e, o);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
